// File: rtl/main_control_fsm.sv
// Multicycle main controller for the CPE-CPU datapath.
// Sequences fetch/decode/execute/mem/writeback, stalls on mem_ready and traps on bad opcodes or memory timeouts.
module main_control_fsm #(
    parameter logic [5:0]  OP_RTYPE    = 6'b000000,
    parameter logic [5:0]  OP_LW       = 6'b100011,
    parameter logic [5:0]  OP_SW       = 6'b101011,
    parameter logic [5:0]  OP_BEQ      = 6'b000100,
    parameter logic [5:0]  OP_J        = 6'b000010,
    parameter logic [5:0]  OP_ADDI     = 6'b001000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12,
        S_RESET     = 4'd13
    } state_t;

    // The timeout fires on the MEM_TIMEOUT-th consecutive waiting cycle, before the count would reach it.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       bus_cause;
    logic       bus_cause_next;
    logic       waiting;
    logic       timed_out;

    assign waiting   = (cur_state == S_FETCH) || (cur_state == S_MEM_READ) || (cur_state == S_MEM_WRITE);
    assign timed_out = waiting && !mem_ready && (wait_cnt == TIMEOUT_LAST);
    assign state     = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_RESET;
            wait_cnt  <= 8'd0;
            bus_cause <= 1'b0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
            bus_cause <= bus_cause_next;
        end
    end

    always_comb begin
        next_state     = cur_state;
        bus_cause_next = bus_cause;
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        i_or_d         = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        mem_to_reg     = 1'b0;
        reg_dst        = 1'b0;
        reg_write      = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;
        pc_source      = 2'b00;
        illegal_op     = 1'b0;
        bus_error      = 1'b0;

        case (cur_state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state     = S_TRAP;
                    bus_cause_next = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    next_state = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    next_state = S_R_EXEC;
                end else if (opcode == OP_BEQ) begin
                    next_state = S_BRANCH;
                end else if (opcode == OP_J) begin
                    next_state = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    next_state = S_I_EXEC;
                end else begin
                    next_state     = S_TRAP;
                    bus_cause_next = 1'b0;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (timed_out) begin
                    next_state     = S_TRAP;
                    bus_cause_next = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else if (timed_out) begin
                    next_state     = S_TRAP;
                    bus_cause_next = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                illegal_op = !bus_cause;
                bus_error  = bus_cause;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Count only consecutive stalled cycles within one access; any progress or completion restarts it.
        if (waiting && !mem_ready && (next_state == cur_state)) begin
            wait_cnt_next = wait_cnt + 8'd1;
        end else begin
            wait_cnt_next = 8'd0;
        end
    end

endmodule
